// File: rtl/gray_pkg.sv
// Shared constants for the RGB-to-luma path: BT.601-style integer weights,
// rounding offset and the product width of one weighted channel.
package gray_pkg;

  // Weights must sum to 1 << SHIFT so the rounded result always fits one channel.
  localparam int W_R    = 77;
  localparam int W_G    = 150;
  localparam int W_B    = 29;
  localparam int ROUND  = 128;
  localparam int SHIFT  = 8;
  localparam int PROD_W = 16;

endpackage

// File: rtl/gray_luma_calc.sv
// Two-stage luma datapath: stage 1 registers the three weighted products,
// stage 2 registers the rounded, shifted sum. Both stages hold when en=0.
module gray_luma_calc
  import gray_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [3*DATA_WIDTH-1:0] rgb,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   gray
);

  // Product width tracks the channel width; PROD_W is the 8-bit channel case.
  localparam int PW = PROD_W - 8 + DATA_WIDTH;

  logic [PW-1:0] p_r;
  logic [PW-1:0] p_g;
  logic [PW-1:0] p_b;
  logic          s1_valid;
  logic [PW+1:0] sum;
  logic [DATA_WIDTH-1:0] y;

  always_comb begin
    sum = (PW+2)'(p_r) + (PW+2)'(p_g) + (PW+2)'(p_b) + (PW+2)'(ROUND);
    y   = DATA_WIDTH'(sum >> SHIFT);
  end

  // Data registers load only alongside a valid pixel, so idle inputs never disturb them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_r       <= '0;
      p_g       <= '0;
      p_b       <= '0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      gray      <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (in_valid) begin
        p_r <= PW'(rgb[3*DATA_WIDTH-1 -: DATA_WIDTH]) * PW'(W_R);
        p_g <= PW'(rgb[2*DATA_WIDTH-1 -: DATA_WIDTH]) * PW'(W_G);
        p_b <= PW'(rgb[DATA_WIDTH-1:0]) * PW'(W_B);
      end
      if (s1_valid) begin
        gray <= y;
      end
    end
  end

endmodule

// File: rtl/rgb2gray_stage.sv
// RGB pixel to grayscale FIFO producer: handshake and stall control around the
// luma datapath, plus a per-frame write counter that flags the last pixel.
module rgb2gray_stage
  import gray_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FRAME_PIXELS = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [3*DATA_WIDTH-1:0] pix_rgb,
  input  logic                    fifo_full,
  output logic                    fifo_wr,
  output logic [DATA_WIDTH-1:0]   fifo_data,
  output logic                    frame_done
);

  localparam int CW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

  logic          advance;
  logic          accept;
  logic          s2_valid;
  logic          last;
  logic [CW-1:0] count;

  // Handshake: a pixel transfers on a rising edge where pix_valid && pix_ready;
  // the upstream holds pix_rgb while pix_valid is high and pix_ready is low.
  // The pipeline moves whenever its output slot is empty or the FIFO can take it,
  // so bubbles are squeezed out even while the FIFO reports full.
  always_comb begin
    advance    = !s2_valid || !fifo_full;
    pix_ready  = advance;
    accept     = pix_valid && advance;
    fifo_wr    = s2_valid && !fifo_full;
    last       = (count == CW'(FRAME_PIXELS - 1));
    frame_done = fifo_wr && last;
  end

  gray_luma_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_luma (
    .clk      (clk),
    .rstn     (rstn),
    .en       (advance),
    .in_valid (accept),
    .rgb      (pix_rgb),
    .out_valid(s2_valid),
    .gray     (fifo_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (fifo_wr) begin
      count <= last ? '0 : count + CW'(1);
    end
  end

endmodule

// File: tb/tb_rgb2gray_stage.sv
// Scoreboard bench for rgb2gray_stage: random and directed pixels, FIFO
// back-pressure, frame pulses, async reset and a depth-4 FIFO model.
module tb_rgb2gray_stage;
  import gray_pkg::*;

  localparam int DW = 8;
  localparam int FP = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [23:0]   pix_rgb = '0;
  logic          fifo_full = 1'b0;
  logic          fifo_wr;
  logic [DW-1:0] fifo_data;
  logic          frame_done;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [DW-1:0] exp_q[$];
  int            acc_cyc_q[$];
  int            acc_log[$];
  logic [DW-1:0] mdl_fifo[$];

  int wcnt = 0, fd_cnt = 0, wr_total = 0, wr_first = -1, wr_last = -1;
  int rd_idx = 0, rd_cnt = 0;
  bit lat_check = 0, use_tbl = 0, pending = 0, fifo_mode = 0;
  logic [DW-1:0] tbl_exp = '0;
  bit            o_ready, o_wr;
  logic [DW-1:0] o_data;

  rgb2gray_stage #(
    .DATA_WIDTH  (DW),
    .FRAME_PIXELS(FP)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_rgb   (pix_rgb),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_data (fifo_data),
    .frame_done(frame_done)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int luma(logic [23:0] p);
    return (W_R * int'(p[23:16]) + W_G * int'(p[15:8]) + W_B * int'(p[7:0]) + ROUND)
           / (1 << SHIFT);
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // accept recorder: expected luma pushed when a transfer is about to happen
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rstn && pix_valid && pix_ready) begin
      e = use_tbl ? tbl_exp : DW'(luma(pix_rgb));
      exp_q.push_back(e);
      acc_cyc_q.push_back(cyc);
      acc_log.push_back(int'(e));
    end
  end

  // monitor: pops and compares on every FIFO write
  always @(negedge clk) begin
    logic [DW-1:0] e;
    int c;
    if (rstn) begin
      if (fifo_wr) begin
        check("wr_while_full", fifo_full, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stray_write: got write of %0d, expected no write", fifo_data);
        end else begin
          e = exp_q.pop_front();
          c = acc_cyc_q.pop_front();
          check("gray_data", fifo_data, e);
          if (lat_check) check("latency", cyc - c, 2);
        end
        check("frame_done_on_write", frame_done, (wcnt == FP - 1));
        wcnt = (wcnt + 1) % FP;
        wr_total++;
        if (wr_first < 0) wr_first = cyc;
        wr_last = cyc;
        if (frame_done) fd_cnt++;
      end else begin
        check("frame_done_idle", frame_done, 0);
      end
    end
  end

  // driver: one clock cycle; called and returning at posedge+1
  task automatic cycle(input bit v, input bit f, input bit rnd, input bit rd);
    bit w;
    logic [DW-1:0] d, g;
    pix_valid = v || pending;
    fifo_full = fifo_mode ? (mdl_fifo.size() >= 4) : f;
    if (!pending && rnd) pix_rgb = 24'($urandom_range(0, 24'hFFFFFF));
    @(negedge clk);
    o_ready = pix_ready;
    o_data  = fifo_data;
    o_wr    = fifo_wr;
    w = fifo_wr;
    d = fifo_data;
    @(posedge clk);
    #1;
    pending = pix_valid && !o_ready;
    if (fifo_mode) begin
      if (rd && mdl_fifo.size() > 0) begin
        g = mdl_fifo.pop_front();
        check("fifo_read_order", g, acc_log[rd_idx]);
        rd_idx++;
        rd_cnt++;
      end
      if (w) mdl_fifo.push_back(d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp_q.size() > 0 || pending ||
                               (fifo_mode && mdl_fifo.size() > 0)); i++)
      cycle(0, 0, 1, 1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    #2;
    rstn = 1'b0;
    #1;
    check("rst_fifo_wr", fifo_wr, 0);
    check("rst_frame_done", frame_done, 0);
    pix_valid = 1'b0;
    fifo_full = 1'b0;
    pending   = 0;
    fifo_mode = 0;
    exp_q.delete();
    acc_cyc_q.delete();
    mdl_fifo.delete();
    wcnt = 0;
    repeat (2) @(posedge clk);
    #3;
    rstn = 1'b1;
    @(negedge clk);
    check("rst_pix_ready", pix_ready, 1);
    check("rst_fifo_data", fifo_data, 0);
    check("rst_fifo_wr_after", fifo_wr, 0);
    @(posedge clk);
    #1;
  endtask

  logic [23:0]   t_rgb[6];
  logic [DW-1:0] t_y[6];

  initial begin
    int a0, wt0, fd0;
    logic [DW-1:0] d0;
    t_rgb = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h6496C8};
    t_y   = '{8'd255, 8'd0, 8'd77, 8'd149, 8'd29, 8'd141};
    d0 = '0;

    do_reset();

    // 1: directed single pixels with latency check
    lat_check = 1;
    for (int i = 0; i < 6; i++) begin
      use_tbl = 1;
      tbl_exp = t_y[i];
      pix_rgb = t_rgb[i];
      cycle(1, 0, 0, 0);
      use_tbl = 0;
      repeat (3) cycle(0, 0, 0, 0);
    end
    drain();

    // 2: 256 back-to-back random pixels
    wr_first = -1;
    wt0 = wr_total;
    for (int i = 0; i < 256; i++) begin
      cycle(1, 0, 1, 0);
      check("stream_ready", o_ready, 1);
    end
    drain();
    check("stream_writes", wr_total - wt0, 256);
    check("stream_span", wr_last - wr_first, 255);
    lat_check = 0;

    // 3: back-pressure for 5 cycles mid-stream
    a0  = acc_log.size();
    wt0 = wr_total;
    repeat (6) cycle(1, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 1, 0);
      check("stall_ready", o_ready, 0);
      check("stall_no_wr", o_wr, 0);
      if (i == 0) d0 = o_data;
      else check("stall_data_stable", o_data, d0);
    end
    repeat (6) cycle(1, 0, 1, 0);
    drain();
    check("stall_no_loss", wr_total - wt0, acc_log.size() - a0);

    // 4: two frames with random full gaps
    do_reset();
    fd0 = fd_cnt;
    a0  = acc_log.size();
    for (int i = 0; i < 400 && (acc_log.size() - a0) < 32; i++)
      cycle(1, ($urandom_range(0, 2) == 0), 1, 0);
    drain();
    check("frame_pixels", acc_log.size() - a0, 32);
    check("frame_pulses", fd_cnt - fd0, 2);
    check("frame_count_wrap", wcnt, 0);

    // 5: reset with two pixels in flight
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    pix_valid = 1'b0;
    check("pre_reset_wr", fifo_wr, 1);
    do_reset();
    fd0 = fd_cnt;
    a0  = acc_log.size();
    repeat (4) cycle(0, 0, 0, 0);
    for (int i = 0; i < 100 && (acc_log.size() - a0) < 15; i++) cycle(1, 0, 1, 0);
    drain();
    check("post_reset_no_early_frame", fd_cnt - fd0, 0);
    cycle(1, 0, 1, 0);
    drain();
    check("post_reset_frame", fd_cnt - fd0, 1);

    // 6: depth-4 FIFO model with idle reader, then drain it
    do_reset();
    fifo_mode = 1;
    a0 = acc_log.size();
    rd_idx = a0;
    rd_cnt = 0;
    repeat (20) cycle(1, 0, 1, 0);
    check("fifo_accepts", acc_log.size() - a0, 6);
    check("fifo_ready_low", o_ready, 0);
    check("fifo_level", mdl_fifo.size(), 4);
    drain();
    check("fifo_reads", rd_cnt, acc_log.size() - a0);
    fifo_mode = 0;
    fifo_full = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
